uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 28 ++
 rtl/uart_tx_feeder.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between a byte producer, the feeder and a UART
// transmitter. The feeder is the slave; the producer/UART side is the master.
interface uart_tx_feeder_if #(
  parameter int DEPTH = 8
) ();
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     ovf_clr;
  logic                     tx_busy;
  logic                     tx_done;
  logic [7:0]               tx_data;
  logic                     tx_en;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     timeout;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy, tx_done,
    input  tx_data, tx_en, full, empty, count, overflow, timeout
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy, tx_done,
    output tx_data, tx_en, full, empty, count, overflow, timeout
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter: pops one byte whenever the UART
// is free, pulses tx_en, waits for tx_done (bounded by TIMEOUT) and then
// inserts GAP_CYCLES idle clocks before the next byte.
module uart_tx_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 200000
) (
  input logic            clk,
  input logic            rst,
  uart_tx_feeder_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state_r;
  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          overflow_r;
  logic          timeout_r;
  logic          tx_en_r;
  logic [7:0]    tx_data_r;
  logic [TW-1:0] wait_cnt_r;
  logic [GW-1:0] gap_cnt_r;

  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic          to_set_s;
  logic [CW-1:0] count_nxt_s;

  // Push/pop qualification, timeout detection and next occupancy.
  always_comb begin
    push_s    = bus.wr_en && !full_r;
    ovf_set_s = bus.wr_en && full_r;
    pop_s     = (state_r == IDLE) && !empty_r && !bus.tx_busy;
    // wait_cnt_r holds the clocks elapsed since tx_en rose; a late tx_done
    // on the last allowed edge still wins over the timeout.
    to_set_s  = (state_r == WAIT) && !bus.tx_done &&
                (wait_cnt_r == TW'(TIMEOUT - 1));
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers, occupancy flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == '0);
      // A set event outranks a simultaneous clear.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Transmit sequencer with registered tx_en/tx_data and the timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      tx_en_r    <= 1'b0;
      tx_data_r  <= 8'h00;
      wait_cnt_r <= '0;
      gap_cnt_r  <= '0;
      timeout_r  <= 1'b0;
    end else begin
      tx_en_r <= 1'b0;
      if (to_set_s) begin
        timeout_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        timeout_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            tx_data_r  <= mem_r[rd_ptr_r];
            tx_en_r    <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          // tx_done is deliberately not looked at here.
          wait_cnt_r <= TW'(1);
          state_r    <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done || to_set_s) begin
            gap_cnt_r <= '0;
            state_r   <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data  = tx_data_r;
  assign bus.tx_en    = tx_en_r;
  assign bus.full     = full_r;
  assign bus.empty    = empty_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized self-checking bench for uart_tx_feeder. The reference model
// keeps the FIFO as a queue and the transmit link as edge timestamps
// (pop edge, completion edge, earliest next pop).
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int GAP   = 16;
  localparam int TMO   = 50;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = CW + 13;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] accepted[$];
  int   k          = 0;
  int   pop_edge   = -100;
  int   free_edge  = 0;
  int   done_at    = -1;
  int   done_delay = 0;
  bit   in_flight  = 1'b0;
  bit   issue_pulse = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_txen = 1'b0;
  logic m_ovf  = 1'b0;
  logic m_to   = 1'b0;

  // bytes and edges observed on the DUT tx port within one test
  int         en_edges[$];
  logic [7:0] en_data[$];

  localparam logic [VW-1:0] RESET_VEC = {CW'(0), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

  function automatic logic [VW-1:0] model_vec();
    return {CW'(q.size()), (q.size() == 0), (q.size() == DEPTH), m_txen, m_data, m_ovf, m_to};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.count, bus.empty, bus.full, bus.tx_en, bus.tx_data, bus.overflow, bus.timeout};
  endfunction

  function automatic void model_reset();
    q.delete();
    in_flight = 1'b0;
    pop_edge  = -100;
    free_edge = 0;
    done_at   = -1;
    m_data    = 8'h00;
    m_txen    = 1'b0;
    m_ovf     = 1'b0;
    m_to      = 1'b0;
  endfunction

  // Drive one cycle of stimulus, advance one edge, update the model.
  task automatic step(input logic wr, input logic [7:0] d, input logic clr,
                      input logic busy, input logic noise);
    logic done, full_b, empty_b, pop, ended, ev_to;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.ovf_clr = clr;
    bus.tx_busy = busy;
    done = noise || (done_at == k + 1) || (issue_pulse && in_flight && (pop_edge == k));
    bus.tx_done = done;
    @(posedge clk);
    k++;
    full_b  = (q.size() == DEPTH);
    empty_b = (q.size() == 0);
    pop     = !in_flight && (k >= free_edge) && !empty_b && !busy;
    ended   = 1'b0;
    ev_to   = 1'b0;
    if (in_flight && (k >= pop_edge + 2)) begin
      if (done) ended = 1'b1;
      else if (k - pop_edge == TMO) begin
        ended = 1'b1;
        ev_to = 1'b1;
      end
    end
    if (ended) begin
      in_flight = 1'b0;
      free_edge = k + GAP + 1;
      done_at   = -1;
    end
    if (pop) begin
      m_data    = q.pop_front();
      in_flight = 1'b1;
      pop_edge  = k;
      done_at   = (done_delay > 0) ? k + done_delay : -1;
    end
    if (wr && !full_b) begin
      q.push_back(d);
      accepted.push_back(d);
    end
    m_txen = pop;
    if (wr && full_b) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (ev_to) m_to = 1'b1;
    else if (clr) m_to = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.ovf_clr = 1'b0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    rst = 1'b0;
    model_reset();
    #23;
    checks++;
    if (dut_vec() !== RESET_VEC) $display("FAIL reset_state: got %h, required %h", dut_vec(), RESET_VEC);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== CW'(1) || bus.empty !== 1'b0)
      $display("FAIL first_push: count %0d empty %b, required 1 0", bus.count, bus.empty);
    else passes++;
    done_delay = 3;
    repeat (30) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_drain k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
  endtask

  task automatic test_single_byte();
    int t0;
    en_edges.delete(); en_data.delete();
    done_delay  = 6;
    issue_pulse = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    t0 = k;
    checks++;
    if (dut_vec() !== model_vec()) $display("FAIL single_push: got %h, required %h", dut_vec(), model_vec());
    else passes++;
    for (int i = 0; i < 50; i++) begin
      step((i == 10) ? 1'b1 : 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL single_cycle k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    issue_pulse = 1'b0;
    checks++;
    if (en_edges.size() != 2)
      $display("FAIL single_pulses: got %0d tx_en pulses, required 2", en_edges.size());
    else if (en_edges[0] != t0 + 1 || en_edges[1] != t0 + 24 || en_data[0] !== 8'hA5 || en_data[1] !== 8'h3C)
      $display("FAIL single_timing: edges +%0d/+%0d data %h/%h, required +1/+24 A5/3C",
               en_edges[0] - t0, en_edges[1] - t0, en_data[0], en_data[1]);
    else passes++;
  endtask

  task automatic test_ordering();
    bit bad;
    en_edges.delete(); en_data.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL order_fill k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== CW'(8)) $display("FAIL order_full: full %b count %0d, required 1 8", bus.full, bus.count);
    else passes++;
    done_delay = 5;
    repeat (200) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL order_cycle k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    bad = (en_data.size() != 8);
    for (int i = 0; i < en_data.size() && !bad; i++) begin
      if (en_data[i] !== 8'(i + 1)) bad = 1'b1;
      if (i > 0 && en_edges[i] - en_edges[i-1] != 5 + GAP + 1) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL order_sequence: got %0d bytes, required 01..08 spaced %0d", en_data.size(), 5 + GAP + 1);
    else passes++;
  endtask

  task automatic test_overflow();
    bit seen_ff;
    en_edges.delete(); en_data.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'($urandom_range(254, 0)), 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL ovf_fill k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(8)) $display("FAIL ovf_set: overflow %b count %0d, required 1 8", bus.overflow, bus.count);
    else passes++;
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", bus.overflow);
    else passes++;
    done_delay = 4;
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
    checks++;
    if (bus.count !== CW'(7) || bus.overflow !== 1'b1 || bus.tx_en !== 1'b1)
      $display("FAIL ovf_push_pop: count %0d overflow %b tx_en %b, required 7 1 1", bus.count, bus.overflow, bus.tx_en);
    else passes++;
    for (int i = 0; i < 180; i++) begin
      step(1'b0, 8'h00, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL ovf_drain k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    seen_ff = 1'b0;
    foreach (en_data[i]) if (en_data[i] === 8'hFF) seen_ff = 1'b1;
    checks++;
    if (seen_ff || en_data.size() != 8) $display("FAIL ovf_no_ff: sent %0d bytes, FF seen %b, required 8 bytes without FF", en_data.size(), seen_ff);
    else passes++;
  endtask

  task automatic test_push_pop();
    bit bad;
    en_edges.delete(); en_data.delete(); accepted.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b1, 1'b0);
    done_delay = 3;
    step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0, 1'b0);
    if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
    checks++;
    if (bus.count !== CW'(3) || bus.tx_en !== 1'b1) $display("FAIL pushpop_count: count %0d tx_en %b, required 3 1", bus.count, bus.tx_en);
    else passes++;
    for (int i = 0; i < 600; i++) begin
      step((i < 500 && q.size() < 3) ? 1'b1 : 1'b0, 8'($urandom_range(255, 0)), 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL pushpop_cycle k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    bad = (en_data.size() < 20) || (en_data.size() != accepted.size());
    for (int i = 0; i < en_data.size() && !bad; i++) if (en_data[i] !== accepted[i]) bad = 1'b1;
    checks++;
    if (bad) $display("FAIL pushpop_order: sent %0d bytes, accepted %0d, required >=20 in push order", en_data.size(), accepted.size());
    else passes++;
  endtask

  task automatic test_timeout();
    int to_edge;
    en_edges.delete(); en_data.delete();
    to_edge = -1;
    done_delay = 0;
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
    repeat (140) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) begin en_edges.push_back(k); en_data.push_back(bus.tx_data); end
      if (bus.timeout === 1'b1 && to_edge < 0) to_edge = k;
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL timeout_cycle k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    checks++;
    if (en_edges.size() != 2)
      $display("FAIL timeout_issue: got %0d tx_en pulses, required 2", en_edges.size());
    else if (to_edge != en_edges[0] + TMO || en_edges[1] != en_edges[0] + TMO + GAP + 1 || en_data[1] !== 8'h22)
      $display("FAIL timeout_timing: flag at +%0d next at +%0d, required +%0d +%0d", to_edge - en_edges[0],
               en_edges[1] - en_edges[0], TMO, TMO + GAP + 1);
    else passes++;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.timeout !== 1'b0) $display("FAIL timeout_clear: got %b, required 0", bus.timeout);
    else passes++;
  endtask

  task automatic test_random();
    repeat (1500) begin
      done_delay = int'($urandom_range(60, 1));
      step(($urandom_range(2, 0) == 0), 8'($urandom_range(255, 0)), ($urandom_range(19, 0) == 0),
           ($urandom_range(5, 0) == 0), ($urandom_range(24, 0) == 0));
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL random_cycle k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int n_en;
    done_delay = 2;
    repeat (300) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
    done_delay = 0;
    repeat (4) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL midrst_pre k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) $display("FAIL midrst_state: got %h, required %h", dut_vec(), RESET_VEC);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    n_en = 0;
    repeat (60) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (bus.tx_en === 1'b1) n_en++;
      checks++;
      if (dut_vec() !== model_vec()) $display("FAIL midrst_after k=%0d: got %h, required %h", k, dut_vec(), model_vec());
      else passes++;
    end
    checks++;
    if (n_en != 0) $display("FAIL midrst_no_tx: got %0d tx_en pulses, required 0", n_en);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_ordering();
    test_overflow();
    test_push_pop();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
